// File: rtl/div_clk_monitor.sv
// div_clk_monitor: measures period/high time of a same-clock divided clock, flags errors, tracks lock and stall.
// Ports: clk, rst (sync, active-high), div_in (divided clock under test);
//        period/high_time (last measurement, CNT_W bits), meas_valid (1-cycle update pulse),
//        period_err, duty_err, locked, stall (status levels).
// Optional feature: define DIV_MON_DUTY_CHECK_EN to enable the high-time counter and duty checking.
module div_clk_monitor #(
  parameter int DIV        = 5,
  parameter int CNT_W      = 16,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 4 * DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             period_err,
  output logic             duty_err,
  output logic             locked,
  output logic             stall
);
  localparam int GC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] DV = CNT_W'(DIV);
  localparam logic [GC_W-1:0] LC = GC_W'(LOCK_COUNT);
  typedef enum logic [1:0] {SEARCH, RUN, STALL} state_e;
  state_e state_q, state_d;
  logic s_q, p_q, rise, tmo, meas, pe, de, good;
  logic [CNT_W-1:0] pc_q, pc_d, period_q, period_d;
  logic [GC_W-1:0] gc_q, gc_d;
  logic mv_q, perr_q, perr_d, locked_q, locked_d, stall_q;
  // No synchronizer: div_in is derived from clk itself.
  assign rise = s_q & ~p_q;
  // A rise on the timeout cycle wins over the stall.
  assign tmo  = (pc_q == TO) & ~rise;
  assign meas = rise & (state_q == RUN);
  assign pe   = pc_q != DV;
`ifdef DIV_MON_DUTY_CHECK_EN
  localparam logic [CNT_W-1:0] HLO = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] HHI = CNT_W'((DIV + 1) / 2);
  logic [CNT_W-1:0] hc_q, hc_d, hi_q, hi_d;
  logic derr_q, derr_d;
  assign de        = (hc_q < HLO) | (hc_q > HHI);
  assign high_time = hi_q;
  assign duty_err  = derr_q;
  always_comb begin
    hc_d   = rise ? CNT_W'(1) : (s_q && hc_q != TO) ? hc_q + 1'b1 : hc_q;
    hi_d   = meas ? hc_q : hi_q;
    derr_d = meas ? de : derr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q   <= '0;
      hi_q   <= '0;
      derr_q <= 1'b0;
    end else begin
      hc_q   <= hc_d;
      hi_q   <= hi_d;
      derr_q <= derr_d;
    end
  end
`else
  assign de        = 1'b0;
  assign high_time = '0;
  assign duty_err  = 1'b0;
`endif
  assign good       = ~pe & ~de;
  assign period     = period_q;
  assign meas_valid = mv_q;
  assign period_err = perr_q;
  assign locked     = locked_q;
  assign stall      = stall_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEARCH;
      s_q      <= 1'b0;
      p_q      <= 1'b0;
      pc_q     <= '0;
      gc_q     <= '0;
      period_q <= '0;
      mv_q     <= 1'b0;
      perr_q   <= 1'b0;
      locked_q <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= div_in;
      p_q      <= s_q;
      pc_q     <= pc_d;
      gc_q     <= gc_d;
      period_q <= period_d;
      mv_q     <= meas;
      perr_q   <= perr_d;
      locked_q <= locked_d;
      stall_q  <= state_d == STALL;
    end
  end
  always_comb begin
    state_d = rise ? RUN : tmo ? STALL : state_q;
  end
  always_comb begin
    pc_d     = rise ? CNT_W'(1) : (pc_q == TO) ? pc_q : pc_q + 1'b1;
    period_d = meas ? pc_q : period_q;
    perr_d   = meas ? pe : perr_q;
    gc_d     = (state_d == STALL) ? '0 : !meas ? gc_q : !good ? '0 : (gc_q == LC) ? gc_q : gc_q + 1'b1;
    locked_d = (state_d == STALL) ? 1'b0 : !meas ? locked_q : good && (gc_q >= LC - 1'b1);
  end
endmodule

// File: tb/tb_div_clk_monitor.sv
// tb_div_clk_monitor: scoreboard bench for div_clk_monitor with DIV=5, LOCK_COUNT=4, TIMEOUT=20.
module tb_div_clk_monitor;
  localparam int DIV = 5;
  localparam int CNT_W = 16;
  localparam int LC = 4;
`ifdef DIV_MON_DUTY_CHECK_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, div_in = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic meas_valid, period_err, duty_err, locked, stall;
  typedef struct {int per; int hi; bit pe; bit de; bit lk; int at;} exp_t;
  exp_t sb[$];
  exp_t me;
  int total = 0, bad = 0, cyc = 0, gc_m = 0, prev_len = 0, prev_hi = 0;
  bit armed = 1'b0;
  div_clk_monitor #(.DIV(DIV), .CNT_W(CNT_W), .LOCK_COUNT(LC), .TIMEOUT(4 * DIV)) dut (
    .clk(clk), .rst(rst), .div_in(div_in), .period(period), .high_time(high_time),
    .meas_valid(meas_valid), .period_err(period_err), .duty_err(duty_err),
    .locked(locked), .stall(stall)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (meas_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL meas_unexpected: meas_valid=1 at cyc %0d period=%0d, required no measurement", cyc, period);
      end else begin
        me = sb.pop_front();
        if (period !== CNT_W'(me.per) || high_time !== CNT_W'(me.hi) || period_err !== me.pe ||
            duty_err !== me.de || locked !== me.lk || cyc != me.at) begin
          bad++;
          $display("FAIL meas: got per=%0d hi=%0d pe=%0b de=%0b lk=%0b cyc=%0d, required per=%0d hi=%0d pe=%0b de=%0b lk=%0b cyc=%0d",
                   period, high_time, period_err, duty_err, locked, cyc, me.per, me.hi, me.pe, me.de, me.lk, me.at);
        end
      end
    end
  end
  task automatic drive(input bit v, input int n);
    repeat (n) begin
      @(posedge clk);
      #1 div_in = v;
    end
  endtask
  task automatic gen_period(input int len, input int hi);
    exp_t e;
    @(posedge clk);
    #1 div_in = 1'b1;
    if (armed) begin
      e.per = prev_len;
      e.hi  = DUTY ? prev_hi : 0;
      e.pe  = prev_len != DIV;
      e.de  = DUTY && (prev_hi < DIV / 2 || prev_hi > (DIV + 1) / 2);
      gc_m  = (!e.pe && !e.de) ? ((gc_m < LC) ? gc_m + 1 : LC) : 0;
      e.lk  = gc_m == LC;
      e.at  = cyc + 2;
      sb.push_back(e);
    end
    armed = 1'b1;
    prev_len = len;
    prev_hi = hi;
    drive(1'b1, hi - 1);
    drive(1'b0, len - hi);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    div_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({period, high_time, meas_valid, period_err, duty_err, locked, stall} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got per=%0d hi=%0d mv=%0b pe=%0b de=%0b lk=%0b st=%0b, required all 0",
               period, high_time, meas_valid, period_err, duty_err, locked, stall);
    end
  endtask
  task automatic test_dead_input;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      total++;
      if (stall !== (i >= 22)) begin
        bad++;
        $display("FAIL dead_stall[%0d]: stall=%0b, required %0b", i, stall, i >= 22);
      end
    end
  endtask
  task automatic test_basic;
    repeat (5) begin
      gen_period(5, 3);
      gen_period(5, 2);
    end
    total++;
    if (locked !== 1'b1 || stall !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL basic_lock: locked=%0b stall=%0b pending=%0d, required 1 0 0", locked, stall, sb.size());
    end
  endtask
  task automatic test_bad_period;
    gen_period(7, 3);
    repeat (5) gen_period(5, 3);
    total++;
    if (locked !== 1'b1 || period_err !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL relock: locked=%0b period_err=%0b pending=%0d, required 1 0 0", locked, period_err, sb.size());
    end
  endtask
  task automatic test_duty;
    repeat (5) gen_period(5, 4);
    total++;
    if (locked !== !DUTY || duty_err !== DUTY || sb.size() != 0) begin
      bad++;
      $display("FAIL duty: locked=%0b duty_err=%0b pending=%0d, required %0b %0b 0", locked, duty_err, sb.size(), !DUTY, DUTY);
    end
  endtask
  task automatic test_stall;
    repeat (6) gen_period(5, 3);
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      total++;
      if (stall !== (i >= 19) || locked !== (i < 19)) begin
        bad++;
        $display("FAIL stall[%0d]: stall=%0b locked=%0b, required %0b %0b", i, stall, locked, i >= 19, i < 19);
      end
    end
    armed = 1'b0;
    gc_m = 0;
    repeat (6) gen_period(5, 3);
    total++;
    if (locked !== 1'b1 || stall !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL stall_resume: locked=%0b stall=%0b pending=%0d, required 1 0 0", locked, stall, sb.size());
    end
  endtask
  task automatic test_reset_mid;
    gen_period(5, 3);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({period, high_time, meas_valid, period_err, duty_err, locked, stall} !== '0) begin
      bad++;
      $display("FAIL reset_mid: got per=%0d hi=%0d mv=%0b pe=%0b de=%0b lk=%0b st=%0b, required all 0",
               period, high_time, meas_valid, period_err, duty_err, locked, stall);
    end
    armed = 1'b0;
    gc_m = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) gen_period(5, 2);
    total++;
    if (locked !== 1'b0 || period !== CNT_W'(DIV) || sb.size() != 0) begin
      bad++;
      $display("FAIL reset_mid_after: locked=%0b period=%0d pending=%0d, required 0 %0d 0", locked, period, sb.size(), DIV);
    end
  endtask
  initial begin
    test_reset;
    test_dead_input;
    test_basic;
    test_bad_period;
    test_duty;
    test_stall;
    test_reset_mid;
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
